// File: rtl/vp_gfx_serializer.sv
// rtl/vp_gfx_serializer.sv - cell-row graphics pixel serializer
module vp_gfx_serializer #(
  parameter int CELL_WIDTH = 16,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pixel_ce,
  input  logic                  cell_start,
  input  logic [3:0]            foreground,
  input  logic [3:0]            background,
  input  logic [CELL_WIDTH-1:0] bitmap,
  input  logic                  enable,
  input  logic                  invert,
  output logic [3:0]            pixel_color,
  output logic                  pixel_valid,
  output logic                  cell_done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(CELL_WIDTH - 1);

  state_t                state;
  logic [CELL_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      cnt;
  logic [3:0]            fg_q;
  logic [3:0]            bg_q;

  logic [3:0]            load_fg;
  logic [3:0]            load_bg;
  logic [CELL_WIDTH-1:0] shreg_next;
  logic [CNT_W-1:0]      cnt_next;

  // Colour pair as it will be latched for a new cell, and the next shift step
  assign load_fg    = invert ? background : foreground;
  assign load_bg    = invert ? foreground : background;
  assign shreg_next = shreg << 1;
  assign cnt_next   = cnt + CNT_W'(1);

  // Cell load / shift / end-of-cell sequencing with registered pixel outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      pixel_color <= '0;
      pixel_valid <= 1'b0;
      cell_done   <= 1'b0;
    end else if (pixel_ce) begin
      if (cell_start && enable) begin
        // New cell: first pixel is shown straight from the incoming bitmap
        shreg       <= bitmap;
        cnt         <= '0;
        fg_q        <= load_fg;
        bg_q        <= load_bg;
        state       <= SHIFT;
        pixel_color <= bitmap[CELL_WIDTH-1] ? load_fg : load_bg;
        pixel_valid <= 1'b1;
        cell_done   <= 1'b0;
      end else if (cell_start) begin
        // Non-graphics cell aborts whatever was playing, without cell_done
        state       <= IDLE;
        pixel_color <= '0;
        pixel_valid <= 1'b0;
        cell_done   <= 1'b0;
      end else if (state == SHIFT) begin
        if (cnt == LAST_PIX) begin
          state       <= IDLE;
          pixel_color <= '0;
          pixel_valid <= 1'b0;
          cell_done   <= 1'b0;
        end else begin
          shreg       <= shreg_next;
          cnt         <= cnt_next;
          pixel_color <= shreg_next[CELL_WIDTH-1] ? fg_q : bg_q;
          pixel_valid <= 1'b1;
          cell_done   <= (cnt_next == LAST_PIX);
        end
      end else begin
        pixel_color <= '0;
        pixel_valid <= 1'b0;
        cell_done   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vp_gfx_serializer.sv
// tb/tb_vp_gfx_serializer.sv - scoreboard bench for vp_gfx_serializer
module tb_vp_gfx_serializer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset, pixel_ce, cell_start, enable, invert;
  logic [3:0]   foreground, background;
  logic [W-1:0] bitmap;
  logic [3:0]   pixel_color;
  logic         pixel_valid, cell_done;

  int checks = 0;
  int failures = 0;

  // Expected output triple {color, valid, done} for each clock edge
  logic [5:0] exp_q[$];
  // Colours still to be shown for the cell in progress
  logic [3:0] pend[$];
  logic [5:0] cur_exp = '0;

  vp_gfx_serializer #(.CELL_WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .pixel_ce(pixel_ce), .cell_start(cell_start),
    .foreground(foreground), .background(background), .bitmap(bitmap),
    .enable(enable), .invert(invert), .pixel_color(pixel_color),
    .pixel_valid(pixel_valid), .cell_done(cell_done)
  );

  always #5 clk = ~clk;

  // Apply one clock's worth of inputs and predict what the next edge yields
  task automatic step(input logic rst, input logic ce, input logic cs,
                      input logic en, input logic inv, input logic [3:0] fg,
                      input logic [3:0] bg, input logic [W-1:0] bm);
    logic [3:0] f, b, c;
    @(negedge clk);
    reset = rst; pixel_ce = ce; cell_start = cs; enable = en;
    invert = inv; foreground = fg; background = bg; bitmap = bm;
    if (rst) begin
      pend.delete();
      cur_exp = '0;
    end else if (ce) begin
      if (cs && en) begin
        f = inv ? bg : fg;
        b = inv ? fg : bg;
        pend.delete();
        for (int i = W - 1; i >= 0; i--) pend.push_back(bm[i] ? f : b);
        c = pend.pop_front();
        cur_exp = {c, 1'b1, 1'b0};
      end else if (cs) begin
        pend.delete();
        cur_exp = '0;
      end else if (pend.size() > 0) begin
        c = pend.pop_front();
        cur_exp = {c, 1'b1, (pend.size() == 0)};
      end else begin
        cur_exp = '0;
      end
    end
    exp_q.push_back(cur_exp);
  endtask

  task automatic play(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 1, 0, 4'h0, 4'h0, '0);
  endtask

  // Monitor: compare each edge's outputs against the oldest prediction
  always @(posedge clk) begin
    logic [5:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({pixel_color, pixel_valid, cell_done} !== e) begin
        failures++;
        $display("FAIL pix t=%0t got color=%h valid=%b done=%b want color=%h valid=%b done=%b",
                 $time, pixel_color, pixel_valid, cell_done, e[5:2], e[1], e[0]);
      end
    end
  end

  initial begin
    reset = 1; pixel_ce = 0; cell_start = 0; enable = 0; invert = 0;
    foreground = 0; background = 0; bitmap = '0;

    step(1, 0, 0, 0, 0, 4'h0, 4'h0, '0);
    step(1, 1, 1, 1, 0, 4'hF, 4'hF, 16'hFFFF);
    play(2);

    // Basic cell, then the inverted version
    step(0, 1, 1, 1, 0, 4'hC, 4'h1, 16'hA000);
    play(17);
    step(0, 1, 1, 1, 1, 4'hC, 4'h1, 16'hA000);
    play(17);

    // Back-to-back cells, second start during the last pixel of the first
    step(0, 1, 1, 1, 0, 4'h7, 4'h2, 16'hFFFF);
    play(15);
    step(0, 1, 1, 1, 0, 4'h7, 4'h2, 16'h0000);
    play(17);

    // Pixel clock-enable at half rate; starts while ce=0 must be ignored
    step(0, 1, 1, 1, 0, 4'h5, 4'hA, 16'h9C3B);
    for (int j = 0; j < 31; j++) begin
      if (j % 2 == 0) step(0, 0, (j % 4 == 0), (j % 8 == 0), 0, 4'h3, 4'h4, 16'h1234);
      else            step(0, 1, 0, 1, 0, 4'h0, 4'h0, '0);
    end
    play(3);

    // Mid-cell cancel at pixel 5, then mid-cell reload at pixel 5
    step(0, 1, 1, 1, 0, 4'h6, 4'h9, 16'hF0F0);
    play(5);
    step(0, 1, 1, 0, 0, 4'h6, 4'h9, 16'hFFFF);
    play(3);
    step(0, 1, 1, 1, 0, 4'h6, 4'h9, 16'hF0F0);
    play(5);
    step(0, 1, 1, 1, 0, 4'hE, 4'h3, 16'h5A5A);
    play(17);

    // Reset in the middle of a cell, then a normal cell
    step(0, 1, 1, 1, 0, 4'hB, 4'h4, 16'hC3C3);
    play(8);
    step(1, 1, 0, 1, 0, 4'h0, 4'h0, '0);
    step(0, 1, 1, 1, 0, 4'h8, 4'h1, 16'h8001);
    play(17);

    // Random traffic
    for (int k = 0; k < 1500; k++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0),
           1'($urandom), 4'($urandom), 4'($urandom), W'($urandom));
    play(20);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
